// File: rtl/dm_responder.sv
// Single-outstanding word memory responder: accepts one request in IDLE,
// answers with a one-cycle response pulse exactly LATENCY cycles later.
module dm_responder #(
   parameter int DEPTH_WORDS = 3072,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic        cap_we_q, cap_we_d;
   logic [29:0] cap_widx_q, cap_widx_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]  cap_be_q, cap_be_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept, enter_resp, in_range, wr_en;
   logic          sel_we;
   logic [29:0]   sel_widx;
   logic [31:0]   sel_wdata, rd_word, wr_word;
   logic [3:0]    sel_be;
   logic [AW-1:0] idx;
   logic          addr_lsb_unused;

   assign addr_lsb_unused = ^req_addr[1:0];

   // With LATENCY=1 the response is produced straight from the accept cycle,
   // so the datapath looks at the live request instead of the captured one.
   always_comb begin
      accept     = (state_q == IDLE) && req_valid;
      sel_we     = accept ? req_we         : cap_we_q;
      sel_widx   = accept ? req_addr[31:2] : cap_widx_q;
      sel_wdata  = accept ? req_wdata      : cap_wdata_q;
      sel_be     = accept ? req_be         : cap_be_q;
      in_range   = {2'b00, sel_widx} < 32'(DEPTH_WORDS);
      idx        = sel_widx[AW-1:0];
      rd_word    = in_range ? mem_q[idx] : '0;
      wr_word    = rd_word;
      for (int b = 0; b < 4; b++)
         if (sel_be[b]) wr_word[8*b +: 8] = sel_wdata[8*b +: 8];
      enter_resp = (accept && (LATENCY == 1)) ||
                   ((state_q == BUSY) && (count_q == 4'd1));
      wr_en      = enter_resp && sel_we && in_range;
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      cap_we_d     = cap_we_q;
      cap_widx_d   = cap_widx_q;
      cap_wdata_d  = cap_wdata_q;
      cap_be_d     = cap_be_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            cap_we_d    = req_we;
            cap_widx_d  = req_addr[31:2];
            cap_wdata_d = req_wdata;
            cap_be_d    = req_be;
            req_ready_d = 1'b0;
            if (LATENCY == 1) state_d = RESP;
            else begin
               state_d = BUSY;
               count_d = 4'(LATENCY - 1);
            end
         end
         BUSY: begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
      if (enter_resp) begin
         resp_valid_d = 1'b1;
         resp_err_d   = !in_range;
         resp_rdata_d = (in_range && !sel_we) ? rd_word : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         cap_we_q     <= 1'b0;
         cap_widx_q   <= '0;
         cap_wdata_q  <= '0;
         cap_be_q     <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cap_we_q     <= cap_we_d;
         cap_widx_q   <= cap_widx_d;
         cap_wdata_q  <= cap_wdata_d;
         cap_be_q     <= cap_be_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Storage commits on the edge that enters RESP; one block per word keeps
   // the asynchronous clear of the whole array simple.
   for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)                           mem_q[w] <= '0;
         else if (wr_en && (idx == AW'(w)))    mem_q[w] <= wr_word;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
endmodule
